ba201v32i_core_wbu: RTL and testbench

BA201V32I_CORE_WBU -- requirements
Module: ba201v32i_core_wbu

---
 rtl/ba201v32i_core_wbu.sv | 104 ++++++++++
 tb/tb_ba201v32i_core_wbu.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ba201v32i_core_wbu.sv
// Write-back unit: arbitrates ALU and load results into one registered
// register-file write port, and tracks loads in flight for hazard detection.
module ba201v32i_core_wbu #(
  parameter int unsigned LOAD_PRIO = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbu_i_alu_valid,
  input  logic [4:0]  wbu_i_alu_rd_addr,
  input  logic [31:0] wbu_i_alu_data,
  output logic        wbu_o_alu_ready,
  input  logic        wbu_i_lsu_valid,
  input  logic [4:0]  wbu_i_lsu_rd_addr,
  input  logic [31:0] wbu_i_lsu_data,
  output logic        wbu_o_lsu_ready,
  input  logic        wbu_i_iss_load,
  input  logic [4:0]  wbu_i_iss_rd_addr,
  input  logic [4:0]  wbu_i_rs1_addr,
  input  logic [4:0]  wbu_i_rs2_addr,
  output logic        wbu_o_stall,
  output logic        wbu_o_rs1_fwd,
  output logic        wbu_o_rs2_fwd,
  output logic [4:0]  wbu_o_rd_addr,
  output logic        wbu_o_rd_wen,
  output logic [31:0] wbu_o_rd_data
);

  localparam int  DATA_W  = 32;
  localparam bit  LOAD_WINS = (LOAD_PRIO != 0);

  logic [31:1]       pend_p0;
  logic [31:0]       pend_all;
  logic [31:0]       pend_nxt;
  logic              alu_acc;
  logic              lsu_acc;
  logic              any_acc;
  logic [4:0]        win_addr;
  logic [DATA_W-1:0] win_data;
  logic              iss_set;

  logic              rd_vld_p0;
  logic [4:0]        rd_addr_p0;
  logic [DATA_W-1:0] rd_data_p0;

  // x0 is never pending; padding bit 0 lets addresses index directly.
  assign pend_all = {pend_p0, 1'b0};

  assign wbu_o_alu_ready = wbu_i_alu_valid & (~wbu_i_lsu_valid | ~LOAD_WINS);
  assign wbu_o_lsu_ready = wbu_i_lsu_valid & (~wbu_i_alu_valid | LOAD_WINS);

  assign alu_acc  = wbu_i_alu_valid & wbu_o_alu_ready;
  assign lsu_acc  = wbu_i_lsu_valid & wbu_o_lsu_ready;
  assign any_acc  = alu_acc | lsu_acc;
  assign win_addr = lsu_acc ? wbu_i_lsu_rd_addr : wbu_i_alu_rd_addr;
  assign win_data = lsu_acc ? wbu_i_lsu_data    : wbu_i_alu_data;

  // Stall uses this cycle's pending bits only; a same-cycle return does not
  // release the stall until the following cycle.
  assign wbu_o_stall = pend_all[wbu_i_rs1_addr]
                     | pend_all[wbu_i_rs2_addr]
                     | (wbu_i_iss_load & pend_all[wbu_i_iss_rd_addr]);

  assign iss_set = wbu_i_iss_load & ~wbu_o_stall & (wbu_i_iss_rd_addr != 5'd0);

  // Clear before set so a same-register issue and return leaves it pending.
  always_comb begin
    pend_nxt = pend_all;
    if (lsu_acc)
      pend_nxt[wbu_i_lsu_rd_addr] = 1'b0;
    if (iss_set)
      pend_nxt[wbu_i_iss_rd_addr] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pend_p0 <= '0;
    else
      pend_p0 <= pend_nxt[31:1];
  end

  // ---- stage p0: registered register-file write ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_p0  <= 1'b0;
      rd_addr_p0 <= '0;
      rd_data_p0 <= '0;
    end else begin
      rd_vld_p0 <= any_acc & (win_addr != 5'd0);
      if (any_acc) begin
        rd_addr_p0 <= win_addr;
        rd_data_p0 <= win_data;
      end
    end
  end

  assign wbu_o_rd_wen  = rd_vld_p0;
  assign wbu_o_rd_addr = rd_addr_p0;
  assign wbu_o_rd_data = rd_data_p0;

  assign wbu_o_rs1_fwd = rd_vld_p0 & (wbu_i_rs1_addr != 5'd0) & (wbu_i_rs1_addr == rd_addr_p0);
  assign wbu_o_rs2_fwd = rd_vld_p0 & (wbu_i_rs2_addr != 5'd0) & (wbu_i_rs2_addr == rd_addr_p0);

endmodule

// File: tb/tb_ba201v32i_core_wbu.sv
// Bench for ba201v32i_core_wbu: one instance per arbitration priority, a
// behavioural model per instance, and a write-port scoreboard.
module tb_ba201v32i_core_wbu;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid [2];
  logic [4:0]  alu_addr  [2];
  logic [31:0] alu_data  [2];
  logic        alu_ready [2];
  logic        lsu_valid [2];
  logic [4:0]  lsu_addr  [2];
  logic [31:0] lsu_data  [2];
  logic        lsu_ready [2];
  logic        iss_load  [2];
  logic [4:0]  iss_rd    [2];
  logic [4:0]  rs1       [2];
  logic [4:0]  rs2       [2];
  logic        stall     [2];
  logic        fwd1      [2];
  logic        fwd2      [2];
  logic [4:0]  rd_addr   [2];
  logic        rd_wen    [2];
  logic [31:0] rd_data   [2];

  int  n_cmp = 0;
  int  n_err = 0;
  bit  chk_en = 0;
  bit  mon_en = 0;
  bit  pend  [2][32];
  bit  m_wen [2];
  logic [4:0] m_addr [2];
  bit  a_acc [2];
  bit  l_acc [2];
  wr_t q0[$];
  wr_t q1[$];

  always #5 clk = ~clk;

  ba201v32i_core_wbu #(.LOAD_PRIO(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .wbu_i_alu_valid(alu_valid[0]), .wbu_i_alu_rd_addr(alu_addr[0]),
    .wbu_i_alu_data(alu_data[0]), .wbu_o_alu_ready(alu_ready[0]),
    .wbu_i_lsu_valid(lsu_valid[0]), .wbu_i_lsu_rd_addr(lsu_addr[0]),
    .wbu_i_lsu_data(lsu_data[0]), .wbu_o_lsu_ready(lsu_ready[0]),
    .wbu_i_iss_load(iss_load[0]), .wbu_i_iss_rd_addr(iss_rd[0]),
    .wbu_i_rs1_addr(rs1[0]), .wbu_i_rs2_addr(rs2[0]),
    .wbu_o_stall(stall[0]), .wbu_o_rs1_fwd(fwd1[0]), .wbu_o_rs2_fwd(fwd2[0]),
    .wbu_o_rd_addr(rd_addr[0]), .wbu_o_rd_wen(rd_wen[0]), .wbu_o_rd_data(rd_data[0])
  );

  ba201v32i_core_wbu #(.LOAD_PRIO(0)) u_dut1 (
    .clk(clk), .rst(rst),
    .wbu_i_alu_valid(alu_valid[1]), .wbu_i_alu_rd_addr(alu_addr[1]),
    .wbu_i_alu_data(alu_data[1]), .wbu_o_alu_ready(alu_ready[1]),
    .wbu_i_lsu_valid(lsu_valid[1]), .wbu_i_lsu_rd_addr(lsu_addr[1]),
    .wbu_i_lsu_data(lsu_data[1]), .wbu_o_lsu_ready(lsu_ready[1]),
    .wbu_i_iss_load(iss_load[1]), .wbu_i_iss_rd_addr(iss_rd[1]),
    .wbu_i_rs1_addr(rs1[1]), .wbu_i_rs2_addr(rs2[1]),
    .wbu_o_stall(stall[1]), .wbu_o_rs1_fwd(fwd1[1]), .wbu_o_rs2_fwd(fwd2[1]),
    .wbu_o_rd_addr(rd_addr[1]), .wbu_o_rd_wen(rd_wen[1]), .wbu_o_rd_data(rd_data[1])
  );

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every register-file write must match the oldest
  // expected write for that instance.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        if (rd_wen[i] !== 1'b0) begin
          wr_t e;
          int  sz;
          sz = (i == 0) ? q0.size() : q1.size();
          if (sz == 0) begin
            chk("wr_unexpected", i, 32'(rd_wen[i]), 32'd0);
          end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk("wr_addr", i, 32'(rd_addr[i]), 32'(e.addr));
            chk("wr_data", i, rd_data[i], e.data);
          end
        end
      end
    end
  end

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      alu_valid[i] = 0; alu_addr[i] = 0; alu_data[i] = 0;
      lsu_valid[i] = 0; lsu_addr[i] = 0; lsu_data[i] = 0;
      iss_load[i] = 0; iss_rd[i] = 0; rs1[i] = 0; rs2[i] = 0;
    end
  endtask

  // One clock: check combinational outputs against the model, advance the
  // model to the state after the coming edge, then cross the edge.
  task automatic cycle(input logic r);
    rst = r;
    #1;
    for (int i = 0; i < 2; i++) begin
      bit  prio_load, ar, lr, st, f1, f2;
      wr_t w;
      prio_load = (i == 0);
      ar = alu_valid[i] && (!lsu_valid[i] || !prio_load);
      lr = lsu_valid[i] && (!alu_valid[i] || prio_load);
      st = (rs1[i] != 0 && pend[i][rs1[i]]) || (rs2[i] != 0 && pend[i][rs2[i]]) ||
           (iss_load[i] && iss_rd[i] != 0 && pend[i][iss_rd[i]]);
      f1 = m_wen[i] && rs1[i] != 0 && rs1[i] == m_addr[i];
      f2 = m_wen[i] && rs2[i] != 0 && rs2[i] == m_addr[i];
      if (chk_en) begin
        chk("alu_ready", i, 32'(alu_ready[i]), 32'(ar));
        chk("lsu_ready", i, 32'(lsu_ready[i]), 32'(lr));
        chk("stall", i, 32'(stall[i]), 32'(st));
        chk("rs1_fwd", i, 32'(fwd1[i]), 32'(f1));
        chk("rs2_fwd", i, 32'(fwd2[i]), 32'(f2));
      end
      a_acc[i] = ar;
      l_acc[i] = lr;
      if (r) begin
        for (int k = 0; k < 32; k++) pend[i][k] = 0;
        m_wen[i] = 0;
        m_addr[i] = 0;
      end else begin
        m_wen[i] = 0;
        if (ar || lr) begin
          w.addr = lr ? lsu_addr[i] : alu_addr[i];
          w.data = lr ? lsu_data[i] : alu_data[i];
          if (w.addr != 0) begin
            m_wen[i] = 1;
            m_addr[i] = w.addr;
            if (i == 0) q0.push_back(w); else q1.push_back(w);
          end
        end
        if (lr && lsu_addr[i] != 0) pend[i][lsu_addr[i]] = 0;
        if (iss_load[i] && !st && iss_rd[i] != 0) pend[i][iss_rd[i]] = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drop_accepted();
    for (int i = 0; i < 2; i++) begin
      if (a_acc[i]) alu_valid[i] = 0;
      if (l_acc[i]) lsu_valid[i] = 0;
    end
  endtask

  task automatic set_alu(input logic [4:0] a, input logic [31:0] d);
    for (int i = 0; i < 2; i++) begin alu_valid[i] = 1; alu_addr[i] = a; alu_data[i] = d; end
  endtask

  task automatic set_lsu(input logic [4:0] a, input logic [31:0] d);
    for (int i = 0; i < 2; i++) begin lsu_valid[i] = 1; lsu_addr[i] = a; lsu_data[i] = d; end
  endtask

  task automatic set_iss(input logic v, input logic [4:0] a);
    for (int i = 0; i < 2; i++) begin iss_load[i] = v; iss_rd[i] = a; end
  endtask

  task automatic set_rs(input logic [4:0] a1, input logic [4:0] a2);
    for (int i = 0; i < 2; i++) begin rs1[i] = a1; rs2[i] = a2; end
  endtask

  initial begin
    idle();
    cycle(1'b1);
    chk_en = 1;
    mon_en = 1;
    cycle(1'b1);
    for (int i = 0; i < 2; i++) begin
      chk("rst_wen", i, 32'(rd_wen[i]), 32'd0);
      chk("rst_addr", i, 32'(rd_addr[i]), 32'd0);
      chk("rst_data", i, rd_data[i], 32'd0);
    end

    // ALU only
    set_alu(5'd5, 32'h1234_5678);
    cycle(1'b0);
    drop_accepted();
    for (int i = 0; i < 2; i++) begin
      chk("alu_only_wen", i, 32'(rd_wen[i]), 32'd1);
      chk("alu_only_addr", i, 32'(rd_addr[i]), 32'd5);
      chk("alu_only_data", i, rd_data[i], 32'h1234_5678);
    end
    cycle(1'b0);

    // Simultaneous offers: inst0 favours loads, inst1 favours the ALU
    set_alu(5'd3, 32'hA);
    set_lsu(5'd4, 32'hB);
    cycle(1'b0);
    drop_accepted();
    chk("sim_first", 0, 32'(rd_addr[0]), 32'd4);
    chk("sim_first", 1, 32'(rd_addr[1]), 32'd3);
    cycle(1'b0);
    drop_accepted();
    chk("sim_second", 0, 32'(rd_addr[0]), 32'd3);
    chk("sim_second", 1, 32'(rd_addr[1]), 32'd4);
    cycle(1'b0);

    // Load-use hazard on x7
    set_iss(1'b1, 5'd7);
    cycle(1'b0);
    set_iss(1'b0, 5'd0);
    set_rs(5'd7, 5'd0);
    cycle(1'b0);
    cycle(1'b0);
    for (int i = 0; i < 2; i++) chk("hazard_stall", i, 32'(stall[i]), 32'd1);
    set_lsu(5'd7, 32'h0000_0777);
    cycle(1'b0);
    drop_accepted();
    for (int i = 0; i < 2; i++) begin
      chk("hazard_release", i, 32'(stall[i]), 32'd0);
      chk("hazard_fwd", i, 32'(fwd1[i]), 32'd1);
    end
    cycle(1'b0);
    set_rs(5'd0, 5'd0);

    // x0 writes and issues
    set_alu(5'd0, 32'hDEAD_BEEF);
    cycle(1'b0);
    drop_accepted();
    for (int i = 0; i < 2; i++) chk("x0_wen", i, 32'(rd_wen[i]), 32'd0);
    set_iss(1'b1, 5'd0);
    cycle(1'b0);
    cycle(1'b0);
    for (int i = 0; i < 2; i++) chk("x0_no_stall", i, 32'(stall[i]), 32'd0);
    set_iss(1'b0, 5'd0);

    // Issue and return to x9 together, then reset mid-operation
    set_iss(1'b1, 5'd9);
    set_lsu(5'd9, 32'h0000_0999);
    cycle(1'b0);
    drop_accepted();
    set_iss(1'b0, 5'd0);
    set_rs(5'd0, 5'd9);
    cycle(1'b0);
    for (int i = 0; i < 2; i++) chk("x9_pending", i, 32'(stall[i]), 32'd1);
    cycle(1'b1);
    for (int i = 0; i < 2; i++) begin
      chk("midrst_stall", i, 32'(stall[i]), 32'd0);
      chk("midrst_wen", i, 32'(rd_wen[i]), 32'd0);
    end
    set_lsu(5'd9, 32'h0000_9999);
    cycle(1'b0);
    drop_accepted();
    idle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!alu_valid[i] || a_acc[i]) begin
          alu_valid[i] = ($urandom_range(0, 2) != 0);
          alu_addr[i]  = 5'($urandom_range(0, 7));
          alu_data[i]  = $urandom;
        end
        if (!lsu_valid[i] || l_acc[i]) begin
          lsu_valid[i] = ($urandom_range(0, 2) != 0);
          lsu_addr[i]  = 5'($urandom_range(0, 7));
          lsu_data[i]  = $urandom;
        end
        iss_load[i] = ($urandom_range(0, 3) == 0);
        iss_rd[i]   = 5'($urandom_range(0, 7));
        rs1[i]      = 5'($urandom_range(0, 7));
        rs2[i]      = 5'($urandom_range(0, 7));
      end
      cycle(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
    end

    idle();
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b0);
    chk("drain", 0, 32'(q0.size()), 32'd0);
    chk("drain", 1, 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
